unit_responder: RTL and testbench

//  Responder side of the thread unit interface (unit_sel/unit_ctrl/unit_in -> unit_out/unit_ready).

---
 rtl/unit_responder_pkg.sv | 43 ++++
 rtl/unit_responder_alu.sv | 26 ++
 rtl/unit_responder.sv | 120 ++++++++++++
 tb/tb_unit_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/unit_responder_pkg.sv
// Shared types for the thread unit interface: selectors, control codes,
// responder FSM states and the latched memory command.
package unit_responder_pkg;

    typedef logic [31:0] word_t;
    typedef logic [2:0]  ctrl_t;

    typedef enum logic [1:0] {
        UNIT_SEL_NONE = 2'd0,
        UNIT_SEL_ALU  = 2'd1,
        UNIT_SEL_MEM  = 2'd2
    } unit_sel_t;

    localparam ctrl_t ALU_CTRL_ADD = 3'd0;
    localparam ctrl_t ALU_CTRL_SUB = 3'd1;
    localparam ctrl_t ALU_CTRL_AND = 3'd2;
    localparam ctrl_t ALU_CTRL_OR  = 3'd3;
    localparam ctrl_t ALU_CTRL_XOR = 3'd4;
    localparam ctrl_t ALU_CTRL_SLL = 3'd5;
    localparam ctrl_t ALU_CTRL_SRL = 3'd6;
    localparam ctrl_t ALU_CTRL_SLT = 3'd7;

    localparam ctrl_t MEM_CTRL_READ  = 3'd0;
    localparam ctrl_t MEM_CTRL_WRITE = 3'd1;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_REQ  = 2'd1,
        RESP_DONE = 2'd2
    } resp_state_t;

    typedef struct packed {
        logic  we;
        word_t addr;
        word_t wdata;
    } mem_cmd_t;

    // A memory request may go to the bus only if the op is known and word-aligned.
    function automatic logic mem_cmd_ok(input ctrl_t ctrl, input word_t addr);
        return ((ctrl == MEM_CTRL_READ) || (ctrl == MEM_CTRL_WRITE)) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/unit_responder_alu.sv
// Combinational ALU serving zero-wait thread requests.
module alu
    import unit_responder_pkg::*;
(
    input  ctrl_t ctrl,
    input  word_t a,
    input  word_t b,
    output word_t y
);

    always_comb begin
        y = '0;
        case (ctrl)
            ALU_CTRL_ADD: y = a + b;
            ALU_CTRL_SUB: y = a - b;
            ALU_CTRL_AND: y = a & b;
            ALU_CTRL_OR:  y = a | b;
            ALU_CTRL_XOR: y = a ^ b;
            ALU_CTRL_SLL: y = a << b[4:0];
            ALU_CTRL_SRL: y = a >> b[4:0];
            ALU_CTRL_SLT: y = {31'd0, $signed(a) < $signed(b)};
            default:      y = '0;
        endcase
    end

endmodule

// File: rtl/unit_responder.sv
// Responder for one thread: ALU requests answer combinationally, memory
// requests become single-word req/ack bus transactions with timeout.
module unit_responder
    import unit_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter word_t       ERR_WORD       = 32'hDEAD_BEEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  unit_sel_t       unit_sel,
    input  ctrl_t           unit_ctrl,
    input  logic [1:0][31:0] unit_in,
    output word_t           unit_out,
    output logic            unit_ready,
    output logic            mem_req,
    output logic            mem_we,
    output word_t           mem_addr,
    output word_t           mem_wdata,
    input  word_t           mem_rdata,
    input  logic            mem_ack,
    output logic            bus_err,
    input  logic            err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    resp_state_t      state;
    logic [CNT_W-1:0] cnt;
    word_t            cap;
    mem_cmd_t         cmd;
    word_t            alu_y;
    logic             req_ok;
    logic             timeout;
    logic             err_set;

    alu u_alu (
        .ctrl (unit_ctrl),
        .a    (unit_in[0]),
        .b    (unit_in[1]),
        .y    (alu_y)
    );

    assign req_ok  = mem_cmd_ok(unit_ctrl, unit_in[0]);
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // An ack in the final wait cycle still completes the transfer cleanly.
    assign err_set = ((state == RESP_IDLE) && (unit_sel == UNIT_SEL_MEM) && !req_ok) ||
                     ((state == RESP_REQ) && !mem_ack && timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RESP_IDLE;
            cnt     <= '0;
            cap     <= '0;
            cmd     <= '0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                RESP_IDLE: begin
                    if (unit_sel == UNIT_SEL_MEM) begin
                        cmd <= '{we: (unit_ctrl == MEM_CTRL_WRITE), addr: unit_in[0], wdata: unit_in[1]};
                        cnt <= '0;
                        if (req_ok) begin
                            state <= RESP_REQ;
                        end else begin
                            cap   <= ERR_WORD;
                            state <= RESP_DONE;
                        end
                    end
                end
                RESP_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ack) begin
                        cap   <= cmd.we ? '0 : mem_rdata;
                        state <= RESP_DONE;
                    end else if (timeout) begin
                        cap   <= ERR_WORD;
                        state <= RESP_DONE;
                    end
                end
                RESP_DONE: state <= RESP_IDLE;
                default:   state <= RESP_IDLE;
            endcase

            if (err_set)
                bus_err <= 1'b1;
            else if (err_clr)
                bus_err <= 1'b0;
        end
    end

    // Ready is gated by reset so a held-in-reset responder never advances the thread.
    always_comb begin
        unit_ready = 1'b0;
        unit_out   = '0;
        if (rst_n) begin
            case (state)
                RESP_IDLE: begin
                    if (unit_sel == UNIT_SEL_ALU) begin
                        unit_ready = 1'b1;
                        unit_out   = alu_y;
                    end else if (unit_sel != UNIT_SEL_MEM) begin
                        unit_ready = 1'b1;
                    end
                end
                RESP_DONE: begin
                    unit_ready = 1'b1;
                    unit_out   = cap;
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state == RESP_REQ);
    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

endmodule

// File: tb/tb_unit_responder.sv
// Directed plus randomized checks of unit_responder against a transaction-level model.
module tb_unit_responder;
    import unit_responder_pkg::*;

    localparam int unsigned T   = 4;
    localparam word_t       ERR = 32'hDEAD_BEEF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    unit_sel_t        unit_sel;
    ctrl_t            unit_ctrl;
    logic [1:0][31:0] unit_in;
    word_t            unit_out;
    logic             unit_ready;
    logic             mem_req;
    logic             mem_we;
    word_t            mem_addr;
    word_t            mem_wdata;
    word_t            mem_rdata;
    logic             mem_ack;
    logic             bus_err;
    logic             err_clr;

    int   checks = 0;
    int   errors = 0;
    logic berr_m = 1'b0;

    unit_responder #(.TIMEOUT_CYCLES(T), .ERR_WORD(ERR)) dut (
        .clk(clk), .rst_n(rst_n), .unit_sel(unit_sel), .unit_ctrl(unit_ctrl),
        .unit_in(unit_in), .unit_out(unit_out), .unit_ready(unit_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t alu_ref(input ctrl_t c, input word_t a, input word_t b);
        case (c)
            ALU_CTRL_ADD: return a + b;
            ALU_CTRL_SUB: return a - b;
            ALU_CTRL_AND: return a & b;
            ALU_CTRL_OR:  return a | b;
            ALU_CTRL_XOR: return a ^ b;
            ALU_CTRL_SLL: return a << b[4:0];
            ALU_CTRL_SRL: return a >> b[4:0];
            default:      return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Advance one clock, updating the sticky-error model with the value present this cycle.
    task automatic step(input logic set_err);
        if (set_err)      berr_m = 1'b1;
        else if (err_clr) berr_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_idle(input logic clr);
        unit_sel = UNIT_SEL_NONE;
        err_clr  = clr;
        mem_ack  = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_ready", unit_ready, 1);
        chk("idle_out", unit_out, 0);
        chk("idle_mem_req", mem_req, 0);
        chk("idle_bus_err", bus_err, berr_m);
        step(1'b0);
        err_clr = 1'b0;
    endtask

    task automatic do_alu(input ctrl_t c, input word_t a, input word_t b);
        unit_sel   = UNIT_SEL_ALU;
        unit_ctrl  = c;
        unit_in[0] = a;
        unit_in[1] = b;
        mem_ack    = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("alu_ready", unit_ready, 1);
        chk("alu_out", unit_out, alu_ref(c, a, b));
        chk("alu_mem_req", mem_req, 0);
        chk("alu_bus_err", bus_err, berr_m);
        step(1'b0);
    endtask

    // ack_at: REQ cycle (1-based) in which memory acks; outside 1..T means never.
    task automatic do_mem(input ctrl_t c, input word_t addr, input word_t wdata,
                          input int ack_at, input word_t rdata, input logic clr);
        logic  ok     = ((c == MEM_CTRL_READ) || (c == MEM_CTRL_WRITE)) && (addr[1:0] == 2'b00);
        logic  acked  = ok && (ack_at >= 1) && (ack_at <= int'(T));
        int    n_req  = !ok ? 0 : (acked ? ack_at : int'(T));
        word_t exp    = !acked ? ERR : ((c == MEM_CTRL_WRITE) ? 32'd0 : rdata);
        unit_sel   = UNIT_SEL_MEM;
        unit_ctrl  = c;
        unit_in[0] = addr;
        unit_in[1] = wdata;
        err_clr    = clr;
        mem_ack    = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        @(negedge clk);
        chk("mem_idle_ready", unit_ready, 0);
        chk("mem_idle_req", mem_req, 0);
        chk("mem_idle_bus_err", bus_err, berr_m);
        step(!ok);
        err_clr = 1'b0;
        for (int k = 1; k <= n_req; k++) begin
            mem_ack    = (k == ack_at);
            mem_rdata  = (k == ack_at) ? rdata : $urandom;
            unit_in[0] = $urandom;
            unit_in[1] = $urandom;
            @(negedge clk);
            chk("req_mem_req", mem_req, 1);
            chk("req_ready", unit_ready, 0);
            chk("req_we", mem_we, (c == MEM_CTRL_WRITE));
            chk("req_addr", mem_addr, addr);
            if (c == MEM_CTRL_WRITE) chk("req_wdata", mem_wdata, wdata);
            chk("req_bus_err", bus_err, berr_m);
            step((k == n_req) && !acked);
        end
        unit_in[0] = addr;
        unit_in[1] = wdata;
        mem_ack    = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("done_ready", unit_ready, 1);
        chk("done_out", unit_out, exp);
        chk("done_mem_req", mem_req, 0);
        chk("done_bus_err", bus_err, berr_m);
        step(1'b0);
        do_idle(1'b0);
    endtask

    initial begin
        unit_sel   = UNIT_SEL_NONE;
        unit_ctrl  = '0;
        unit_in    = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
        err_clr    = 1'b0;
        #2;
        chk("rst_ready", unit_ready, 0);
        chk("rst_out", unit_out, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_bus_err", bus_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_alu(ALU_CTRL_ADD, 32'd5, 32'd7);
        do_mem(MEM_CTRL_READ, 32'h100, 32'h0, 3, 32'hCAFE_F00D, 1'b0);
        do_mem(MEM_CTRL_WRITE, 32'h40, 32'h1234, 1, $urandom, 1'b0);
        do_mem(MEM_CTRL_READ, 32'h102, 32'h0, 1, $urandom, 1'b0);
        do_idle(1'b0);
        do_idle(1'b1);
        do_mem(MEM_CTRL_READ, 32'h200, 32'h0, 0, $urandom, 1'b0);
        do_idle(1'b1);
        do_mem(MEM_CTRL_READ, 32'h204, 32'h0, int'(T), 32'h0BAD_CAFE, 1'b0);
        do_mem(MEM_CTRL_WRITE, 32'h301, 32'h55, 1, $urandom, 1'b1);
        do_mem(3'd5, 32'h400, 32'h66, 1, $urandom, 1'b1);
        do_idle(1'b1);

        // Reset in the middle of a bus transaction.
        unit_sel   = UNIT_SEL_MEM;
        unit_ctrl  = MEM_CTRL_READ;
        unit_in[0] = 32'h300;
        mem_ack    = 1'b0;
        step(1'b0);
        step(1'b0);
        chk("pre_rst_mem_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_ready", unit_ready, 0);
        chk("midrst_out", unit_out, 0);
        chk("midrst_bus_err", bus_err, 0);
        berr_m   = 1'b0;
        unit_sel = UNIT_SEL_NONE;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_idle(1'b0);
        do_mem(MEM_CTRL_READ, 32'h300, 32'h0, 2, 32'h1357_9BDF, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int    kind = int'($urandom_range(0, 9));
            word_t a    = $urandom;
            word_t b    = $urandom;
            if (kind < 3) begin
                do_alu(ctrl_t'($urandom_range(0, 7)), a, b);
            end else if (kind == 3) begin
                do_idle(1'($urandom_range(0, 1)));
            end else begin
                ctrl_t c = ($urandom_range(0, 9) == 0) ? ctrl_t'($urandom_range(2, 7))
                                                       : ctrl_t'($urandom_range(0, 1));
                if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
                do_mem(c, a, b, int'($urandom_range(0, T + 1)), $urandom, 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
